// File: rtl/risc_prog_loader.sv
// risc_prog_loader: streams a program image into veri_Risc memory, resets the CPU, runs it and counts clocks to halt
module risc_prog_loader #(
  parameter int RST_CYCLES = 1,
  parameter int MAX_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  load_len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [4:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        cpu_rst,
  input  logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] CPU_RST = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] TIMEOUT = 3'd5;
  logic [2:0] state;
  logic [5:0] cnt, len, len_c;
  logic [3:0] rcnt;
  logic       xfer, can_start;
  assign len_c     = load_len > 6'd32 ? 6'd32 : load_len;
  assign in_ready  = state == LOAD;
  assign xfer      = in_valid & in_ready;
  assign mem_wr    = xfer;
  assign mem_addr  = cnt[4:0];
  assign mem_wdata = in_data;
  assign cpu_rst   = !(state == RUN || state == DONE);
  assign busy      = state == LOAD || state == CPU_RST || state == RUN;
  assign done      = state == DONE;
  assign timeout   = state == TIMEOUT;
  assign can_start = state == IDLE || state == DONE || state == TIMEOUT;
  // sequencer: load bytes, hold cpu reset, count run clocks until halt or limit
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      rcnt   <= '0;
      cycles <= '0;
    end else if (can_start) begin
      if (start) begin
        state  <= len_c == 6'd0 ? CPU_RST : LOAD;
        len    <= len_c;
        cnt    <= '0;
        rcnt   <= '0;
        cycles <= '0;
      end
    end else if (state == LOAD) begin
      if (xfer) begin
        cnt <= cnt + 6'd1;
        if (cnt == len - 6'd1) state <= CPU_RST;
      end
    end else if (state == CPU_RST) begin
      rcnt <= rcnt + 4'd1;
      if (rcnt == 4'(RST_CYCLES - 1)) state <= RUN;
    end else if (state == RUN) begin
      if (cpu_halt) state <= DONE;
      else if (cycles == 16'(MAX_CYCLES - 1)) begin
        cycles <= 16'(MAX_CYCLES);
        state  <= TIMEOUT;
      end else cycles <= cycles + 16'd1;
    end else state <= IDLE;
  end
endmodule

// File: tb/tb_risc_prog_loader.sv
// tb_risc_prog_loader: directed scenarios with a write scoreboard and a stand-in halt driver
`timescale 1ns/1ps
module tb_risc_prog_loader;
  localparam int RSTC = 2;
  localparam int MAXC = 64;
  logic clk = 0, rst, start, in_valid, cpu_halt;
  logic [5:0] load_len;
  logic [7:0] in_data, mem_wdata;
  logic in_ready, mem_wr, cpu_rst, busy, done, timeout;
  logic [4:0] mem_addr;
  logic [15:0] cycles;
  int total = 0, bad = 0, nwr = 0, n;
  logic [12:0] sb[$];
  logic [7:0] prog[$];

  risc_prog_loader #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every memory write must match the oldest byte the bench expects to land
  always @(negedge clk)
    if (mem_wr !== 1'b0) begin
      nwr++;
      chk("mem_write", 32'({mem_addr, mem_wdata}), sb.size() != 0 ? 32'(sb.pop_front()) : 32'hffffffff);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(int len);
    nwr = 0;
    start = 1;
    load_len = 6'(len);
    step();
    start = 0;
  endtask

  task automatic send(int clamp, bit gaps);
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps && i % 2 == 1) step();
      in_valid = 1;
      in_data = prog[i];
      chk("in_ready", 32'(in_ready), 32'(i < clamp));
      if (i < clamp) sb.push_back({i[4:0], prog[i]});
      step();
      in_valid = 0;
    end
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    while (cpu_rst === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  task automatic run_halt(int k);
    cpu_halt = 0;
    repeat (k) step();
    chk("run_cycles", 32'(cycles), 32'(k));
    chk("run_busy", 32'(busy), 1);
    cpu_halt = 1;
    step();
    cpu_halt = 0;
    chk("done", 32'(done), 1);
    chk("done_cycles", 32'(cycles), 32'(k));
    chk("done_cpu_rst", 32'(cpu_rst), 0);
    chk("done_busy", 32'(busy), 0);
    step();
    chk("done_frozen", 32'(cycles), 32'(k));
  endtask

  task automatic reset_vals(string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_cycles"}, 32'(cycles), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; load_len = 0; in_valid = 0; in_data = 0; cpu_halt = 0;
    step(); step();
    rst = 0;
    reset_vals("reset");
    // single HLT byte
    prog = '{8'h00};
    start_load(1);
    chk("t1_busy", 32'(busy), 1);
    send(1, 0);
    chk("t1_writes", nwr, 1);
    wait_run(n);
    chk("t1_rst_len", n, RSTC);
    run_halt(4);
    // JMP/JMP/HLT with valid gaps
    prog = '{8'hE2, 8'hE2, 8'h00};
    start_load(3);
    chk("t2_done_clr", 32'(done), 0);
    send(3, 1);
    chk("t2_writes", nwr, 3);
    wait_run(n);
    chk("t2_rst_len", n, RSTC);
    run_halt(12);
    // nine-byte STO program
    prog = '{8'hA7, 8'hC8, 8'hA8, 8'h20, 8'h00, 8'hE6, 8'h00, 8'h01, 8'h00};
    start_load(9);
    send(9, 1);
    chk("t3_writes", nwr, 9);
    wait_run(n);
    run_halt(36);
    // run limit
    prog = '{8'hE0};
    start_load(1);
    send(1, 0);
    wait_run(n);
    cpu_halt = 0;
    n = 0;
    while (timeout !== 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_cycles", 32'(cycles), MAXC);
    chk("t4_cpu_rst", 32'(cpu_rst), 1);
    chk("t4_done", 32'(done), 0);
    step();
    chk("t4_saturate", 32'(cycles), MAXC);
    // reset mid-load after 3 of 5 bytes
    prog = '{8'h11, 8'h22, 8'h33};
    start_load(5);
    chk("t5_timeout_clr", 32'(timeout), 0);
    send(5, 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    rst = 1;
    step();
    rst = 0;
    reset_vals("t5_rst_load");
    // restart loads from address 0, then reset mid-run
    prog = '{8'h44, 8'h55};
    start_load(2);
    send(2, 0);
    chk("t5_writes", nwr, 2);
    wait_run(n);
    cpu_halt = 0;
    repeat (5) step();
    start = 1;
    load_len = 6'd3;
    step();
    start = 0;
    chk("t5_start_ign_busy", 32'(busy), 1);
    chk("t5_start_ign_cycles", 32'(cycles), 6);
    chk("t5_start_ign_rst", 32'(cpu_rst), 0);
    rst = 1;
    step();
    rst = 0;
    reset_vals("t5_rst_run");
    // zero-length load runs on existing memory
    prog.delete();
    start_load(0);
    chk("t6_in_ready", 32'(in_ready), 0);
    wait_run(n);
    chk("t6_rst_len", n, RSTC);
    run_halt(5);
    chk("t6_no_writes", nwr, 0);
    // oversize length clamps to 32
    for (int i = 0; i < 33; i++) prog.push_back(8'(i * 7 + 3));
    start_load(40);
    send(32, 0);
    chk("t6_writes", nwr, 32);
    chk("t6_sb_empty", sb.size(), 0);
    wait_run(n);
    chk("t6_rst_len_tail", n, RSTC - 1);
    run_halt(7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
